// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multi-cycle RV32I control sequencer:
//   - state_t    : sequencer state encoding (4 bits)
//   - OPC_*      : major opcodes handled by the v1 subset
//   - RS2_*      : ALU B-operand select encodings
//   - SUB_*      : ALU subtract-control encodings
//   - CMP_*      : bit positions inside the ALU compare flag vector
//   - F3_*       : func3 values the sequencer needs to recognise
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        MEM_WB   = 4'd7,
        ALU_WB   = 4'd8,
        BRANCH   = 4'd9,
        PC_INC   = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] RS2_REG  = 2'd0;
    localparam logic [1:0] RS2_FOUR = 2'd1;
    localparam logic [1:0] RS2_IMM  = 2'd2;

    localparam logic [1:0] SUB_ADD  = 2'd0;
    localparam logic [1:0] SUB_SUB  = 2'd1;
    localparam logic [1:0] SUB_INST = 2'd2;

    localparam int CMP_EQ  = 0;
    localparam int CMP_LT  = 1;
    localparam int CMP_LTU = 2;

    // Shift-right immediates (SRLI/SRAI) take the add/sub bit from InstReg[30].
    localparam logic [2:0] F3_SR = 3'b101;

    // func3 010/011 are not defined branch conditions.
    function automatic logic branch_f3_legal(input logic [2:0] f3);
        return f3[2:1] != 2'b01;
    endfunction

endpackage

// File: rtl/mc_control_fsm_branch_cond.sv
// -----------------------------------------------------------------------------
// branch_cond
// Combinational branch resolution from func3 and the ALU compare flags.
// Ports:
//   i_func3   [2:0] : branch func3 field
//   i_compare [2:0] : {ltu, lt, eq} flags from the ALU
//   o_taken         : 1 when the branch condition holds
// -----------------------------------------------------------------------------
module branch_cond
    import mc_ctrl_pkg::*;
(
    input  logic [2:0] i_func3,
    input  logic [2:0] i_compare,
    output logic       o_taken
);

    logic w_base;

    // func3[2:1] picks the relation, func3[0] inverts it (BNE/BGE/BGEU).
    always_comb begin
        w_base  = 1'b0;
        o_taken = 1'b0;
        case (i_func3[2:1])
            2'b00:   w_base = i_compare[CMP_EQ];
            2'b10:   w_base = i_compare[CMP_LT];
            2'b11:   w_base = i_compare[CMP_LTU];
            default: w_base = 1'b0;
        endcase
        if (branch_f3_legal(i_func3)) begin
            o_taken = w_base ^ i_func3[0];
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
// Multi-cycle control sequencer for the RV32I datapath. One state per
// datapath step; outputs are a Moore decode of state, gated by mem_ready
// (FETCH IRWrite) and branch resolution (BRANCH).
// Ports:
//   clk, clr            : clock, synchronous active-high reset
//   opcode, func3       : fields of InstReg
//   compare             : ALU flags {ltu, lt, eq}
//   mem_ready           : RAM completes the current access this cycle
//   PCWrite .. S_PC     : datapath strobes and mux selects
//   Branch              : branch taken this cycle
//   illegal             : halted in TRAP
//   retired [CNT_W-1:0] : completed-instruction count (wraps)
// -----------------------------------------------------------------------------
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [2:0]       compare,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IorD,
    output logic             MemoryRead,
    output logic             MemoryWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             S_rs1,
    output logic [1:0]       S_rs2,
    output logic             S_func3,
    output logic [1:0]       S_sub,
    output logic             S_PC,
    output logic             Branch,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t           r_state;
    state_t           w_next;
    logic             w_taken;
    logic [CNT_W-1:0] r_retired;

    branch_cond u_branch_cond (
        .i_func3   (func3),
        .i_compare (compare),
        .o_taken   (w_taken)
    );

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            FETCH:    if (mem_ready) w_next = DECODE;
            DECODE: begin
                case (opcode)
                    OPC_OP:              w_next = EXEC_R;
                    OPC_OPIMM:           w_next = EXEC_I;
                    OPC_LOAD, OPC_STORE: w_next = MEM_ADDR;
                    OPC_BRANCH:          w_next = branch_f3_legal(func3) ? BRANCH : TRAP;
                    default:             w_next = TRAP;
                endcase
            end
            EXEC_R:   w_next = ALU_WB;
            EXEC_I:   w_next = ALU_WB;
            MEM_ADDR: w_next = (opcode == OPC_STORE) ? MEM_WR : MEM_RD;
            MEM_RD:   if (mem_ready) w_next = MEM_WB;
            MEM_WR:   if (mem_ready) w_next = PC_INC;
            MEM_WB:   w_next = FETCH;
            ALU_WB:   w_next = FETCH;
            BRANCH:   w_next = w_taken ? FETCH : PC_INC;
            PC_INC:   w_next = FETCH;
            TRAP:     w_next = TRAP;
            default:  w_next = FETCH;
        endcase
    end

    // Output decode
    always_comb begin
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        MemoryRead  = 1'b0;
        MemoryWrite = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        S_rs1       = 1'b0;
        S_rs2       = RS2_REG;
        S_func3     = 1'b0;
        S_sub       = SUB_ADD;
        S_PC        = 1'b0;
        Branch      = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            FETCH: begin
                MemoryRead = 1'b1;
                IRWrite    = mem_ready;
            end
            DECODE: begin
                // ALUOutReg captures PC+imm, the branch target.
                S_rs2 = RS2_IMM;
            end
            EXEC_R: begin
                S_rs1   = 1'b1;
                S_rs2   = RS2_REG;
                S_func3 = 1'b1;
                S_sub   = SUB_INST;
            end
            EXEC_I: begin
                // Only shift-right immediates honour InstReg[30]; for ADDI it is imm data.
                S_rs1   = 1'b1;
                S_rs2   = RS2_IMM;
                S_func3 = 1'b1;
                S_sub   = (func3 == F3_SR) ? SUB_INST : SUB_ADD;
            end
            MEM_ADDR: begin
                S_rs1 = 1'b1;
                S_rs2 = RS2_IMM;
            end
            MEM_RD: begin
                // Address computation kept live so ALUOutReg is stable while waiting.
                IorD       = 1'b1;
                MemoryRead = 1'b1;
                S_rs1      = 1'b1;
                S_rs2      = RS2_IMM;
            end
            MEM_WR: begin
                IorD        = 1'b1;
                MemoryWrite = 1'b1;
                S_rs1       = 1'b1;
                S_rs2       = RS2_IMM;
            end
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                S_rs2    = RS2_FOUR;
                PCWrite  = 1'b1;
            end
            ALU_WB: begin
                RegWrite = 1'b1;
                S_rs2    = RS2_FOUR;
                PCWrite  = 1'b1;
            end
            BRANCH: begin
                // ALU compares rs1-rs2; a taken branch loads PC from ALUOutReg
                // before this edge overwrites it.
                S_rs1 = 1'b1;
                S_rs2 = RS2_REG;
                S_sub = SUB_SUB;
                if (w_taken) begin
                    Branch  = 1'b1;
                    PCWrite = 1'b1;
                    S_PC    = 1'b1;
                end
            end
            PC_INC: begin
                S_rs2   = RS2_FOUR;
                PCWrite = 1'b1;
            end
            TRAP:    illegal = 1'b1;
            default: ;
        endcase
        // Reset abandons the current step at once, including a pending store.
        if (clr) begin
            PCWrite     = 1'b0;
            MemoryRead  = 1'b0;
            MemoryWrite = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            Branch      = 1'b0;
            illegal     = 1'b0;
        end
    end

    // PCWrite fires exactly once per instruction and is already low in reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_retired <= '0;
        end else if (PCWrite) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign retired = r_retired;

endmodule

// File: tb/tb_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_control_fsm
// Table-driven bench for mc_control_fsm: each record holds one cycle of
// inputs plus the expected control word and retired count for that cycle.
// Multi-cycle trap and store-abort sequences are applied by hand afterwards.
// -----------------------------------------------------------------------------
module tb_mc_control_fsm;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             clr;
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic [2:0]       compare;
    logic             mem_ready;
    logic             PCWrite, IorD, MemoryRead, MemoryWrite, IRWrite, MemtoReg, RegWrite;
    logic             S_rs1, S_func3, S_PC, Branch, illegal;
    logic [1:0]       S_rs2, S_sub;
    logic [CNT_W-1:0] retired;

    always #5 clk = ~clk;

    mc_control_fsm #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .clr         (clr),
        .opcode      (opcode),
        .func3       (func3),
        .compare     (compare),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .IorD        (IorD),
        .MemoryRead  (MemoryRead),
        .MemoryWrite (MemoryWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .S_rs1       (S_rs1),
        .S_rs2       (S_rs2),
        .S_func3     (S_func3),
        .S_sub       (S_sub),
        .S_PC        (S_PC),
        .Branch      (Branch),
        .illegal     (illegal),
        .retired     (retired)
    );

    // {PCWrite, IorD, MemoryRead, MemoryWrite, IRWrite, MemtoReg, RegWrite,
    //  S_rs1, S_rs2[1:0], S_func3, S_sub[1:0], S_PC, Branch, illegal}
    logic [15:0] act;
    assign act = {PCWrite, IorD, MemoryRead, MemoryWrite, IRWrite, MemtoReg, RegWrite,
                  S_rs1, S_rs2, S_func3, S_sub, S_PC, Branch, illegal};

    typedef struct {
        string       name;
        logic        clr;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [2:0]  cmp;
        logic        rdy;
        logic [15:0] exp;
        logic [15:0] mask;
        int          ret;   // -1: retired not checked
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0]  cur_opc;
    logic [2:0]  cur_f3;
    logic [15:0] E_FETCH_W, E_FETCH_R, E_DEC, E_EXR, E_EXI, E_EXI_SR, E_MADDR, E_MRD;
    logic [15:0] E_MWR, E_MWB, E_AWB, E_BRT, E_BRN, E_PCINC, E_TRAP, E_ZERO, M_STROBE;

    function automatic logic [15:0] mk(input int pcw, input int iord, input int mr,
                                       input int mw, input int irw, input int m2r,
                                       input int rw, input int rs1, input int rs2,
                                       input int f3, input int sub, input int spc,
                                       input int br, input int ill);
        return {pcw[0], iord[0], mr[0], mw[0], irw[0], m2r[0], rw[0], rs1[0],
                rs2[1:0], f3[0], sub[1:0], spc[0], br[0], ill[0]};
    endfunction

    // Reset cycles compare only strobes, Branch and illegal.
    function automatic vec_t mkrow(input string name, input logic c, input logic [2:0] cmp,
                                   input logic rdy, input logic [15:0] e, input int ret);
        vec_t v;
        v.name = name;
        v.clr  = c;
        v.opc  = cur_opc;
        v.f3   = cur_f3;
        v.cmp  = cmp;
        v.rdy  = rdy;
        v.exp  = e;
        v.mask = c ? M_STROBE : 16'hFFFF;
        v.ret  = ret;
        return v;
    endfunction

    task automatic row(input string name, input logic c, input logic [2:0] cmp,
                       input logic rdy, input logic [15:0] e, input int ret);
        vecs.push_back(mkrow(name, c, cmp, rdy, e, ret));
    endtask

    task automatic apply(input vec_t v);
        clr       = v.clr;
        opcode    = v.opc;
        func3     = v.f3;
        compare   = v.cmp;
        mem_ready = v.rdy;
        @(negedge clk);
        checks++;
        if ((act & v.mask) !== (v.exp & v.mask)) begin
            errors++;
            $display("FAIL %s ctrl got %h want %h", v.name, act & v.mask, v.exp & v.mask);
        end
        if (v.ret >= 0) begin
            checks++;
            if (retired !== CNT_W'(v.ret)) begin
                errors++;
                $display("FAIL %s retired got %0d want %0d", v.name, retired, v.ret);
            end
        end
        checks++;
        if ((MemoryRead && MemoryWrite) || (IRWrite && RegWrite)) begin
            errors++;
            $display("FAIL %s exclusive strobes got MR=%b MW=%b IRW=%b RW=%b want no overlap",
                     v.name, MemoryRead, MemoryWrite, IRWrite, RegWrite);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                pcw iord mr mw irw m2r rw rs1 rs2 f3 sub spc br ill
        E_FETCH_W = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_FETCH_R = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_DEC     = mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
        E_EXR     = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2, 0, 0, 0);
        E_EXI     = mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0);
        E_EXI_SR  = mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 2, 0, 0, 0);
        E_MADDR   = mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
        E_MRD     = mk(0, 1, 1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
        E_MWR     = mk(0, 1, 0, 1, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
        E_MWB     = mk(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
        E_AWB     = mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        E_BRT     = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0);
        E_BRN     = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        E_PCINC   = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        E_TRAP    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        E_ZERO    = 16'h0000;
        M_STROBE  = mk(1, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1);

        clr = 1'b1; opcode = '0; func3 = '0; compare = '0; mem_ready = 1'b0;

        // Reset, then ADD: 4 cycles, write-back and PC update in cycle 4
        cur_opc = 7'b0110011; cur_f3 = 3'b000;
        row("rst0",      1'b1, 3'b000, 1'b0, E_ZERO,    -1);
        row("rst1",      1'b1, 3'b000, 1'b0, E_ZERO,     0);
        row("add_fetch", 1'b0, 3'b000, 1'b1, E_FETCH_R,  0);
        row("add_dec",   1'b0, 3'b000, 1'b1, E_DEC,      0);
        row("add_exec",  1'b0, 3'b000, 1'b1, E_EXR,      0);
        row("add_wb",    1'b0, 3'b000, 1'b1, E_AWB,      0);
        // LW with three wait cycles: 8 cycles
        cur_opc = 7'b0000011; cur_f3 = 3'b010;
        row("lw_fetch",  1'b0, 3'b000, 1'b1, E_FETCH_R,  1);
        row("lw_dec",    1'b0, 3'b000, 1'b1, E_DEC,      1);
        row("lw_addr",   1'b0, 3'b000, 1'b1, E_MADDR,    1);
        row("lw_wait0",  1'b0, 3'b000, 1'b0, E_MRD,      1);
        row("lw_wait1",  1'b0, 3'b000, 1'b0, E_MRD,      1);
        row("lw_wait2",  1'b0, 3'b000, 1'b0, E_MRD,      1);
        row("lw_rd",     1'b0, 3'b000, 1'b1, E_MRD,      1);
        row("lw_wb",     1'b0, 3'b000, 1'b1, E_MWB,      1);
        // BEQ taken (eq=1): 3 cycles
        cur_opc = 7'b1100011; cur_f3 = 3'b000;
        row("beqt_fetch",1'b0, 3'b001, 1'b1, E_FETCH_R,  2);
        row("beqt_dec",  1'b0, 3'b001, 1'b1, E_DEC,      2);
        row("beqt_br",   1'b0, 3'b001, 1'b1, E_BRT,      2);
        // BEQ not taken (eq=0): 4 cycles
        row("beqn_fetch",1'b0, 3'b000, 1'b1, E_FETCH_R,  3);
        row("beqn_dec",  1'b0, 3'b000, 1'b1, E_DEC,      3);
        row("beqn_br",   1'b0, 3'b000, 1'b1, E_BRN,      3);
        row("beqn_pc",   1'b0, 3'b000, 1'b1, E_PCINC,    3);
        // BGEU with ltu=1: not taken
        cur_f3 = 3'b111;
        row("bgeu_fetch",1'b0, 3'b100, 1'b1, E_FETCH_R,  4);
        row("bgeu_dec",  1'b0, 3'b100, 1'b1, E_DEC,      4);
        row("bgeu_br",   1'b0, 3'b100, 1'b1, E_BRN,      4);
        row("bgeu_pc",   1'b0, 3'b100, 1'b1, E_PCINC,    4);
        // BLT with lt=1: taken
        cur_f3 = 3'b100;
        row("blt_fetch", 1'b0, 3'b010, 1'b1, E_FETCH_R,  5);
        row("blt_dec",   1'b0, 3'b010, 1'b1, E_DEC,      5);
        row("blt_br",    1'b0, 3'b010, 1'b1, E_BRT,      5);
        // SRAI: subtract control follows InstReg[30]
        cur_opc = 7'b0010011; cur_f3 = 3'b101;
        row("srai_fetch",1'b0, 3'b000, 1'b1, E_FETCH_R,  6);
        row("srai_dec",  1'b0, 3'b000, 1'b1, E_DEC,      6);
        row("srai_exec", 1'b0, 3'b000, 1'b1, E_EXI_SR,   6);
        row("srai_wb",   1'b0, 3'b000, 1'b1, E_AWB,      6);
        // ADDI: forced add
        cur_f3 = 3'b000;
        row("addi_fetch",1'b0, 3'b000, 1'b1, E_FETCH_R,  7);
        row("addi_dec",  1'b0, 3'b000, 1'b1, E_DEC,      7);
        row("addi_exec", 1'b0, 3'b000, 1'b1, E_EXI,      7);
        row("addi_wb",   1'b0, 3'b000, 1'b1, E_AWB,      7);
        // SW with a fetch wait and one write wait
        cur_opc = 7'b0100011; cur_f3 = 3'b010;
        row("sw_fwait",  1'b0, 3'b000, 1'b0, E_FETCH_W,  8);
        row("sw_fetch",  1'b0, 3'b000, 1'b1, E_FETCH_R,  8);
        row("sw_dec",    1'b0, 3'b000, 1'b1, E_DEC,      8);
        row("sw_addr",   1'b0, 3'b000, 1'b1, E_MADDR,    8);
        row("sw_wait",   1'b0, 3'b000, 1'b0, E_MWR,      8);
        row("sw_wr",     1'b0, 3'b000, 1'b1, E_MWR,      8);
        row("sw_pc",     1'b0, 3'b000, 1'b1, E_PCINC,    8);
        // BNE with eq=1: not taken
        cur_opc = 7'b1100011; cur_f3 = 3'b001;
        row("bne_fetch", 1'b0, 3'b001, 1'b1, E_FETCH_R,  9);
        row("bne_dec",   1'b0, 3'b001, 1'b1, E_DEC,      9);
        row("bne_br",    1'b0, 3'b001, 1'b1, E_BRN,      9);
        row("bne_pc",    1'b0, 3'b001, 1'b1, E_PCINC,    9);
        // BGE with lt=0: taken
        cur_f3 = 3'b101;
        row("bge_fetch", 1'b0, 3'b000, 1'b1, E_FETCH_R, 10);
        row("bge_dec",   1'b0, 3'b000, 1'b1, E_DEC,     10);
        row("bge_br",    1'b0, 3'b000, 1'b1, E_BRT,     10);
        // Branch opcode with func3=010 is undefined: trap, then clr clears the count
        cur_f3 = 3'b010;
        row("b010_fetch",1'b0, 3'b001, 1'b1, E_FETCH_R, 11);
        row("b010_dec",  1'b0, 3'b001, 1'b1, E_DEC,     11);
        row("b010_trap0",1'b0, 3'b001, 1'b1, E_TRAP,    11);
        row("b010_trap1",1'b0, 3'b001, 1'b1, E_TRAP,    11);
        row("b010_clr",  1'b1, 3'b001, 1'b1, E_ZERO,    11);

        foreach (vecs[i]) apply(vecs[i]);

        // LUI traps and stays halted for 10 cycles until clr
        cur_opc = 7'b0110111; cur_f3 = 3'b000;
        apply(mkrow("lui_fetch", 1'b0, 3'b000, 1'b1, E_FETCH_R, 0));
        apply(mkrow("lui_dec",   1'b0, 3'b000, 1'b1, E_DEC,     0));
        for (int k = 0; k < 10; k++) begin
            apply(mkrow("lui_trap", 1'b0, 3'b111, (k % 2) == 0, E_TRAP, 0));
        end
        apply(mkrow("lui_clr",   1'b1, 3'b000, 1'b1, E_ZERO,    0));

        // Resume at FETCH with an ADD
        cur_opc = 7'b0110011;
        apply(mkrow("resume_fetch", 1'b0, 3'b000, 1'b1, E_FETCH_R, 0));
        apply(mkrow("resume_dec",   1'b0, 3'b000, 1'b1, E_DEC,     0));
        apply(mkrow("resume_exec",  1'b0, 3'b000, 1'b1, E_EXR,     0));
        apply(mkrow("resume_wb",    1'b0, 3'b000, 1'b1, E_AWB,     0));

        // Store aborted by clr in MEM_WR: write drops, no PC update, count cleared
        cur_opc = 7'b0100011; cur_f3 = 3'b010;
        apply(mkrow("swx_fetch", 1'b0, 3'b000, 1'b1, E_FETCH_R, 1));
        apply(mkrow("swx_dec",   1'b0, 3'b000, 1'b1, E_DEC,     1));
        apply(mkrow("swx_addr",  1'b0, 3'b000, 1'b1, E_MADDR,   1));
        apply(mkrow("swx_wait",  1'b0, 3'b000, 1'b0, E_MWR,     1));
        apply(mkrow("swx_clr",   1'b1, 3'b000, 1'b1, E_ZERO,    1));
        apply(mkrow("swx_after", 1'b0, 3'b000, 1'b0, E_FETCH_W, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
